// File: rtl/adc_sample_capture_pkg.sv
// Shared definitions for the ADC sample capture front end: capture states,
// mode encodings and the status mask used by the SPI register block.
package adc_sample_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam logic MODE_ASYNC = 1'b0;
  localparam logic MODE_SYNC  = 1'b1;

  localparam logic [31:0] STATUS_CAPTURE_MSK = 32'h0000_0001;

endpackage

// File: rtl/adc_sample_capture_strobe_sync_edge.sv
// ADC strobe synchronizer with rising-edge detector; bypass selects the
// registered strobe directly as a per-cycle accept (synchronous mode).
module strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic bypass,
  input  logic strobe,
  output logic accept
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else if (clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  // The edge history keeps running in bypass so a later async run starts clean.
  assign accept = bypass ? sync_q[0] : rise_q;

endmodule

// File: rtl/adc_sample_capture.sv
// ADC sample capture: accepts strobed offset-binary samples, converts to two's
// complement and counts num_samp per run. Optional watchdog: ADC_TIMEOUT_EN.
module adc_sample_capture
  import adc_sample_capture_pkg::*;
#(
  parameter int SW          = 8,
  parameter int CW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          soft_rst,
  input  logic          start,
  input  logic          mode,
  input  logic [CW-1:0] num_samp,
  input  logic          enable_p,
  input  logic [SW-1:0] sample_p,
  output logic          smp_valid,
  output logic [SW-1:0] smp_data,
  output logic          smp_last,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] smp_cnt
`ifdef ADC_TIMEOUT_EN
  ,
  output logic          timeout
`endif
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("adc_sample_capture: illegal parameter value");
  end

  cap_state_e    state, state_nxt;
  logic          mode_r;
  logic          vld_p0;
  logic [SW-1:0] sample_p0;
  logic          arm, take, is_last, timeout_hit;
  logic [CW:0]   cnt_inc;

  function automatic logic [SW-1:0] ob_to_tc(input logic [SW-1:0] s);
    return {~s[SW-1], s[SW-2:0]};
  endfunction

  // Stage p0: accept event and registered sample
  strobe_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (soft_rst),
    .bypass(mode_r == MODE_SYNC),
    .strobe(enable_p),
    .accept(vld_p0)
  );

  always_ff @(posedge clk) begin
    sample_p0 <= sample_p;
  end

  assign busy    = (state == ARMED) || (state == CAPTURE);
  assign done    = (state == DONE);
  assign arm     = start && ((state == IDLE) || (state == DONE));
  assign take    = vld_p0 && ((state == CAPTURE) || ((state == ARMED) && (num_samp != '0)));
  assign cnt_inc = {1'b0, smp_cnt} + (CW+1)'(1);
  // Live num_samp: shrinking it to or below the count makes the next sample last.
  assign is_last = cnt_inc >= {1'b0, num_samp};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARMED;
      ARMED: begin
        if (num_samp == '0 || timeout_hit) state_nxt = DONE;
        else if (take)                     state_nxt = is_last ? DONE : CAPTURE;
      end
      CAPTURE: if (timeout_hit || (take && is_last)) state_nxt = DONE;
      DONE:    if (start) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
    if (soft_rst) state_nxt = IDLE;
  end

  // Stage p1: converted output sample and run counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      smp_valid <= 1'b0;
      smp_last  <= 1'b0;
      smp_data  <= '0;
      smp_cnt   <= '0;
      mode_r    <= MODE_ASYNC;
    end else if (soft_rst) begin
      smp_valid <= 1'b0;
      smp_last  <= 1'b0;
      smp_data  <= '0;
      smp_cnt   <= '0;
      mode_r    <= MODE_ASYNC;
    end else begin
      smp_valid <= take;
      smp_last  <= take && is_last;
      if (take) smp_data <= ob_to_tc(sample_p0);
      if (arm) begin
        smp_cnt <= '0;
        mode_r  <= mode;
      end else if (take && (cnt_inc <= {1'b0, num_samp})) begin
        smp_cnt <= cnt_inc[CW-1:0];
      end
    end
  end

`ifdef ADC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_cnt;

  assign timeout_hit = busy && !vld_p0 && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (soft_rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (!busy || vld_p0) wd_cnt <= '0;
      else                 wd_cnt <= wd_cnt + WD_W'(1);
      if (arm)              timeout <= 1'b0;
      else if (timeout_hit) timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
- Front-end stage of the FourierTransform core. Sits directly upstream of DataScale and the Goertzel (u_Herzel) filter bank.
- Accepts the ADC enable strobe and 8-bit sample bus, in either asynchronous strobe mode or synchronous per-cycle mode.
- Converts each offset-binary sample to two's complement and emits a one-cycle sample stream.
- Counts exactly num_samp accepted samples per run, then signals done to the SPI status register.

Parameters:
- SW, 8: sample width in bits.
- CW, 32: width of the sample counter and of num_samp.
- SYNC_STAGES, 2: synchronizer depth for enable_p in mode 0. Legal range 2..4.
- TIMEOUT_CYC, 65536: idle-strobe watchdog limit in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  core clock; the same clock that DUT.clkd is derived from.
- rstn  in  1  asynchronous active-low reset.
- soft_rst  in  1  synchronous clear from the RESET_ALL register.
- start  in  1  one-cycle pulse; arms a capture run.
- mode  in  1  0 = asynchronous ADC strobe; 1 = synchronous per-cycle valid.
- num_samp  in  CW  samples per run, from the NUM_SAMP register.
- enable_p  in  1  ADC strobe (mode 0) or sample valid (mode 1).
- sample_p  in  SW  ADC sample, offset binary.
- smp_valid  out  1  one-cycle pulse per accepted sample.
- smp_data  out  SW  two's-complement sample, valid with smp_valid.
- smp_last  out  1  high together with the final smp_valid of a run.
- busy  out  1  high in ARMED and CAPTURE.
- done  out  1  level; high in DONE.
- smp_cnt  out  CW  samples accepted in the current or last run.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all outputs 0; synchronizer and edge history cleared.
- soft_rst: has the same effect as reset but takes effect synchronously on the next clk edge. It overrides start on the same cycle.
- FSM states and transitions:
  - IDLE: start -> ARMED.
  - ARMED: if num_samp==0 -> DONE on the next cycle, with no smp_valid. Otherwise, the first accepted sample moves to CAPTURE.
  - CAPTURE: accept samples. The accepted sample for which smp_cnt+1==num_samp asserts smp_last, and the FSM then moves to DONE.
  - DONE: start -> ARMED, clearing smp_cnt and done. Otherwise hold.
- start is ignored while in ARMED or CAPTURE.
- Mode 0 (asynchronous strobe):
  - enable_p passes through a SYNC_STAGES flop synchronizer. A rising edge on the synchronized signal is the accept event.
  - sample_p is registered once every cycle and is latched on the accept event.
  - Contract: sample_p is stable from at least 1 clk cycle before until SYNC_STAGES+2 cycles after the enable_p rise.
  - Latency: smp_valid goes high SYNC_STAGES+2 clk edges after the first edge that samples enable_p high.
  - A strobe that stays high for many cycles produces exactly one sample.
- Mode 1 (synchronous):
  - enable_p is registered. Every cycle in which the registered enable is high is an accept event.
  - Latency is 2 edges; back-to-back samples give back-to-back smp_valid.
- mode is sampled only at start; changing mode mid-run has no effect until the next run.
- Accept events outside ARMED/CAPTURE are discarded, and the edge detector keeps tracking them.
- Conversion: smp_data = {~sample[SW-1], sample[SW-2:0]}. Example: 0x80 -> 0x00, 0xFF -> 0x7F, 0x00 -> 0x80.
- smp_cnt increments with each smp_valid and saturates at num_samp. It holds through DONE.
- Changing num_samp during a run is permitted; the comparison always uses the live value. If the new value is ≤ smp_cnt, the next accepted sample is treated as last.

Optional Feature:
- Macro: ADC_TIMEOUT_EN.
- With the macro defined:
  - Adds output port timeout (1 bit) and a watchdog counter.
  - The counter clears on every accept event and counts while in ARMED or CAPTURE.
  - When the counter reaches TIMEOUT_CYC-1, timeout is set, the FSM goes to DONE with smp_last never asserted, and smp_cnt holds the partial count.
  - timeout clears on start, soft_rst, or rstn.
- Without the macro: neither the port nor the counter exists, and the FSM waits indefinitely.

Decomposition:
- Shared package: the capture state enum (IDLE, ARMED, CAPTURE, DONE); the mode encodings MODE_ASYNC=0 and MODE_SYNC=1; the STATUS_CAPTURE_MSK bit constant used by the SPI register block.
- One natural sub-module, strobe_sync_edge: a SYNC_STAGES synchronizer plus a rising-edge detector, with a bypass input for mode 1.

Test Plan:
1. Mode 0, ADC period 500 ns, num_samp=5, samples 0x80,0xFF,0x00,0x81,0x7F -> five smp_valid pulses with data 0x00,0x7F,0x80,0x01,0xFF; smp_last on the fifth; done=1; smp_cnt=5.
2. Mode 1, enable_p high for 8 consecutive cycles, num_samp=6 -> six back-to-back smp_valid pulses, first pulse 2 edges after enable; the last two strobes are discarded; done=1.
3. num_samp=0, start -> done=1 one cycle after ARMED; no smp_valid; smp_cnt=0.
4. Mode 0 run with num_samp=5000; soft_rst asserted after 100 samples -> next cycle busy=0, done=0, smp_cnt=0; a new start restarts counting from 0.
5. start pulses injected during CAPTURE and on the same cycle as soft_rst -> ignored; the run completes unchanged (first case) or stays in IDLE (second case).
6. With ADC_TIMEOUT_EN, TIMEOUT_CYC=1000, strobes stop after 3 samples -> timeout=1 and done=1 about 1000 cycles after the last accept; smp_cnt=3; smp_last never asserted.
